frs_message_queue: RTL and testbench

//  Buffers incoming FRS (Function Readiness Status) messages for the FRS Queueing extended capability.

---
 rtl/frs_pkg.sv | 27 ++
 rtl/frs_msg_fifo.sv | 64 ++++++
 rtl/frs_message_queue.sv | 113 +++++++++++
 tb/tb_frs_message_queue.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/frs_pkg.sv
// Shared types for the FRS message queue: message record, interrupt FSM states,
// and the effective-depth clamp used by the top level.
package frs_pkg;

    localparam int unsigned FRS_MAX_DEPTH_W = 12;

    typedef logic [FRS_MAX_DEPTH_W:0] frs_depth_t;

    typedef struct packed {
        logic [15:0] func_id;
        logic [3:0]  reason;
    } frs_msg_t;

    typedef enum logic [1:0] {IDLE, REQ, ARMED} frs_irq_state_e;

    // A programmed depth of 0 still yields one usable entry; never exceed the physical buffer.
    function automatic frs_depth_t frs_eff_depth(input logic [FRS_MAX_DEPTH_W-1:0] max_depth,
                                                 input int unsigned fifo_depth);
        frs_depth_t d;
        d = (max_depth == '0) ? frs_depth_t'(1) : {1'b0, max_depth};
        if (d > frs_depth_t'(fifo_depth)) begin
            d = frs_depth_t'(fifo_depth);
        end
        return d;
    endfunction

endpackage

// File: rtl/frs_msg_fifo.sv
// Circular buffer of FRS messages with a registered head entry.
// The caller guarantees push is only asserted when room remains after any same-cycle pop.
module frs_msg_fifo
    import frs_pkg::*;
#(
    parameter int unsigned Depth  = 16,
    parameter int unsigned CountW = $clog2(Depth + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  frs_msg_t          push_data,
    input  logic              pop,
    output logic [CountW-1:0] count,
    output frs_msg_t          head
);

    localparam int unsigned PtrW = $clog2(Depth);

    frs_msg_t          mem [Depth];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CountW-1:0] count_q, count_d, count_after_pop;
    frs_msg_t          head_q, head_d;

    always_comb begin
        rd_ptr_d        = rd_ptr_q + PtrW'(pop);
        wr_ptr_d        = wr_ptr_q + PtrW'(push);
        count_after_pop = count_q - CountW'(pop);
        count_d         = count_after_pop + CountW'(push);
        // A message written into a queue that is (or just became) empty bypasses the array.
        if (count_d == '0) begin
            head_d = '0;
        end else if (count_after_pop == '0) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/frs_message_queue.sv
// FRS message queue: depth clamp, admission control, RW1C status bits and the
// edge-style MSI request FSM around the message buffer.
module frs_message_queue
    import frs_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               msg_valid,
    input  logic [15:0]                        msg_func_id,
    input  logic [3:0]                         msg_reason,
    input  logic [FRS_MAX_DEPTH_W-1:0]         cfg_max_depth,
    input  logic [4:0]                         cfg_int_msg_num,
    input  logic                               cfg_int_en,
    input  logic                               cfg_dequeue,
    input  logic [1:0]                         cfg_status_w1c,
    output logic [15:0]                        head_func_id,
    output logic [3:0]                         head_reason,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    queue_count,
    output logic                               sts_received,
    output logic                               sts_overflow,
    output logic                               irq_req,
    output logic [4:0]                         irq_vector,
    input  logic                               irq_ack
);

    localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

    logic [CountW-1:0] count;
    frs_depth_t        eff_depth, count_after_pop;
    logic              pop_ok, push_ok, overflow_evt, pend;
    frs_msg_t          in_msg, head;
    frs_irq_state_e    state;

    // Dequeue is applied first, so a full queue still accepts a message popped in the same cycle.
    always_comb begin
        eff_depth       = frs_eff_depth(cfg_max_depth, FIFO_DEPTH);
        pop_ok          = cfg_dequeue && (count != '0);
        count_after_pop = frs_depth_t'(count) - frs_depth_t'(pop_ok);
        push_ok         = msg_valid && (count_after_pop < eff_depth);
        overflow_evt    = msg_valid && !push_ok;
        in_msg.func_id  = msg_func_id;
        in_msg.reason   = msg_reason;
        pend            = cfg_int_en && (sts_received || sts_overflow);
    end

    frs_msg_fifo #(
        .Depth  (FIFO_DEPTH),
        .CountW (CountW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_ok),
        .push_data (in_msg),
        .pop       (pop_ok),
        .count     (count),
        .head      (head)
    );

    // Set beats a same-cycle W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sts_received <= 1'b0;
            sts_overflow <= 1'b0;
        end else begin
            sts_received <= (sts_received && !cfg_status_w1c[0]) || push_ok;
            sts_overflow <= (sts_overflow && !cfg_status_w1c[1]) || overflow_evt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            irq_req    <= 1'b0;
            irq_vector <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pend) begin
                        state      <= REQ;
                        irq_req    <= 1'b1;
                        irq_vector <= cfg_int_msg_num;
                    end
                end
                REQ: begin
                    if (!cfg_int_en) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end else if (irq_ack) begin
                        state   <= ARMED;
                        irq_req <= 1'b0;
                    end
                end
                ARMED: begin
                    // Re-arm only after software has cleared every status bit.
                    if (!sts_received && !sts_overflow) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

    assign head_func_id = head.func_id;
    assign head_reason  = head.reason;
    assign queue_count  = count;

endmodule

// File: tb/tb_frs_message_queue.sv
// Directed, table-driven bench for frs_message_queue (FIFO_DEPTH=16).
module tb_frs_message_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        msg_valid;
    logic [15:0] msg_func_id;
    logic [3:0]  msg_reason;
    logic [11:0] cfg_max_depth;
    logic [4:0]  cfg_int_msg_num;
    logic        cfg_int_en;
    logic        cfg_dequeue;
    logic [1:0]  cfg_status_w1c;
    logic [15:0] head_func_id;
    logic [3:0]  head_reason;
    logic [4:0]  queue_count;
    logic        sts_received;
    logic        sts_overflow;
    logic        irq_req;
    logic [4:0]  irq_vector;
    logic        irq_ack;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frs_message_queue #(
        .FIFO_DEPTH (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .msg_valid       (msg_valid),
        .msg_func_id     (msg_func_id),
        .msg_reason      (msg_reason),
        .cfg_max_depth   (cfg_max_depth),
        .cfg_int_msg_num (cfg_int_msg_num),
        .cfg_int_en      (cfg_int_en),
        .cfg_dequeue     (cfg_dequeue),
        .cfg_status_w1c  (cfg_status_w1c),
        .head_func_id    (head_func_id),
        .head_reason     (head_reason),
        .queue_count     (queue_count),
        .sts_received    (sts_received),
        .sts_overflow    (sts_overflow),
        .irq_req         (irq_req),
        .irq_vector      (irq_vector),
        .irq_ack         (irq_ack)
    );

    typedef struct {
        logic        push;
        logic [15:0] id;
        logic        pop;
        logic [1:0]  w1c;
        logic [11:0] max;
        int          cnt;
        logic [15:0] hid;
        logic        rcv;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    logic [15:0] model[$];

    function automatic vec_t mk(input logic push, input logic [15:0] id, input logic pop,
                                input logic [1:0] w1c, input logic [11:0] max, input int cnt,
                                input logic [15:0] hid, input logic rcv, input logic ovf);
        vec_t v;
        v.push = push; v.id = id; v.pop = pop; v.w1c = w1c; v.max = max;
        v.cnt = cnt; v.hid = hid; v.rcv = rcv; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [3:0] reason_of(input logic [15:0] id);
        logic [3:0] r;
        r = id[3:0] ^ 4'hA;
        return (id == 16'h0) ? 4'h0 : r;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1ns after the rising edge.
    task automatic step(input logic push, input logic [15:0] id, input logic pop,
                        input logic [1:0] w1c);
        msg_valid      = push;
        msg_func_id    = id;
        msg_reason     = id[3:0] ^ 4'hA;
        cfg_dequeue    = pop;
        cfg_status_w1c = w1c;
        @(posedge clk);
        #1;
        msg_valid      = 1'b0;
        cfg_dequeue    = 1'b0;
        cfg_status_w1c = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; msg_valid = 1'b0; msg_func_id = '0; msg_reason = '0;
        cfg_max_depth = 12'd4; cfg_int_msg_num = 5'd0; cfg_int_en = 1'b0;
        cfg_dequeue = 1'b0; cfg_status_w1c = 2'b00; irq_ack = 1'b0;

        vecs.push_back(mk(1, 16'h01, 0, 2'b00, 12'd4, 1, 16'h01, 1, 0));
        vecs.push_back(mk(1, 16'h02, 0, 2'b00, 12'd4, 2, 16'h01, 1, 0));
        vecs.push_back(mk(1, 16'h03, 0, 2'b00, 12'd4, 3, 16'h01, 1, 0));
        vecs.push_back(mk(1, 16'h04, 0, 2'b00, 12'd4, 4, 16'h01, 1, 0));
        vecs.push_back(mk(1, 16'h05, 0, 2'b00, 12'd4, 4, 16'h01, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 3, 16'h02, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 2, 16'h03, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 1, 16'h04, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 0, 16'h00, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 0, 16'h00, 1, 1));
        vecs.push_back(mk(0, 16'h00, 0, 2'b11, 12'd4, 0, 16'h00, 0, 0));
        vecs.push_back(mk(1, 16'h10, 0, 2'b00, 12'd0, 1, 16'h10, 1, 0));
        vecs.push_back(mk(1, 16'h11, 0, 2'b00, 12'd0, 1, 16'h10, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b11, 12'd0, 0, 16'h00, 0, 0));
        vecs.push_back(mk(1, 16'h20, 0, 2'b00, 12'd4, 1, 16'h20, 1, 0));
        vecs.push_back(mk(1, 16'h21, 0, 2'b01, 12'd4, 2, 16'h20, 1, 0));
        vecs.push_back(mk(1, 16'h22, 0, 2'b00, 12'd4, 3, 16'h20, 1, 0));
        vecs.push_back(mk(1, 16'h23, 0, 2'b00, 12'd4, 4, 16'h20, 1, 0));
        vecs.push_back(mk(1, 16'h09, 1, 2'b00, 12'd4, 4, 16'h21, 1, 0));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 3, 16'h22, 1, 0));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 2, 16'h23, 1, 0));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 1, 16'h09, 1, 0));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd4, 0, 16'h00, 1, 0));
        vecs.push_back(mk(0, 16'h00, 0, 2'b11, 12'd4, 0, 16'h00, 0, 0));
        vecs.push_back(mk(1, 16'h30, 0, 2'b00, 12'd4, 1, 16'h30, 1, 0));
        vecs.push_back(mk(1, 16'h31, 0, 2'b00, 12'd4, 2, 16'h30, 1, 0));
        vecs.push_back(mk(1, 16'h32, 0, 2'b00, 12'd4, 3, 16'h30, 1, 0));
        vecs.push_back(mk(1, 16'h33, 0, 2'b00, 12'd1, 3, 16'h30, 1, 1));
        vecs.push_back(mk(1, 16'h34, 1, 2'b00, 12'd1, 2, 16'h31, 1, 1));
        vecs.push_back(mk(0, 16'h00, 1, 2'b11, 12'd1, 1, 16'h32, 0, 0));
        vecs.push_back(mk(0, 16'h00, 1, 2'b00, 12'd1, 0, 16'h00, 0, 0));

        #12;
        check("reset_count", queue_count, 0);
        check("reset_head", head_func_id, 0);
        check("reset_sts", {sts_received, sts_overflow}, 0);
        check("reset_irq", {irq_req, irq_vector}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            cfg_max_depth = vecs[i].max;
            step(vecs[i].push, vecs[i].id, vecs[i].pop, vecs[i].w1c);
            check($sformatf("vec%0d_count", i), queue_count, vecs[i].cnt);
            check($sformatf("vec%0d_head_id", i), head_func_id, vecs[i].hid);
            check($sformatf("vec%0d_head_reason", i), head_reason, reason_of(vecs[i].hid));
            check($sformatf("vec%0d_received", i), sts_received, vecs[i].rcv);
            check($sformatf("vec%0d_overflow", i), sts_overflow, vecs[i].ovf);
        end
        check("irq_idle_when_disabled", irq_req, 0);

        // Interrupt: one request per status assertion.
        cfg_max_depth = 12'd4; cfg_int_en = 1'b1; cfg_int_msg_num = 5'd7;
        step(1, 16'h40, 0, 2'b00);
        check("irq_not_yet", irq_req, 0);
        step(0, 16'h00, 0, 2'b00);
        check("irq_raised", irq_req, 1);
        check("irq_vector7", irq_vector, 7);
        cfg_int_msg_num = 5'd3;
        for (int i = 0; i < 3; i++) step(0, 16'h00, 0, 2'b00);
        check("irq_held", irq_req, 1);
        check("irq_vector_held", irq_vector, 7);
        irq_ack = 1'b1;
        step(0, 16'h00, 0, 2'b00);
        irq_ack = 1'b0;
        check("irq_after_ack", irq_req, 0);
        step(1, 16'h41, 0, 2'b00);
        for (int i = 0; i < 3; i++) step(0, 16'h00, 0, 2'b00);
        check("no_irq_second_push", irq_req, 0);
        step(0, 16'h00, 0, 2'b11);
        check("w1c_cleared", {sts_received, sts_overflow}, 0);
        step(0, 16'h00, 0, 2'b00);
        step(1, 16'h42, 0, 2'b00);
        check("rearm_not_yet", irq_req, 0);
        step(0, 16'h00, 0, 2'b00);
        check("irq_rearmed", irq_req, 1);
        check("irq_vector3", irq_vector, 3);
        cfg_int_en = 1'b0;
        step(0, 16'h00, 0, 2'b00);
        check("irq_drop_on_disable", irq_req, 0);

        for (int i = 0; i < 3; i++) step(0, 16'h00, 1, 2'b00);
        check("drained", queue_count, 0);

        // Pointer wrap at full physical depth.
        cfg_max_depth = 12'd4095;
        cfg_int_en    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1, 16'h100 + 16'(i), 0, 2'b00);
            model.push_back(16'h100 + 16'(i));
        end
        check("wrap_prefill_count", queue_count, 8);
        for (int i = 0; i < 40; i++) begin
            step(1, 16'h200 + 16'(i), 1, 2'b00);
            void'(model.pop_front());
            model.push_back(16'h200 + 16'(i));
            check($sformatf("wrap%0d_head", i), head_func_id, model[0]);
        end
        check("wrap_count", queue_count, 8);
        check("wrap_reason", head_reason, reason_of(model[0]));
        check("irq_before_reset", irq_req, 1);

        // Asynchronous reset mid-stream.
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_count", queue_count, 0);
        check("midrst_sts", {sts_received, sts_overflow}, 0);
        check("midrst_irq", irq_req, 0);
        check("midrst_head", head_func_id, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cfg_int_en = 1'b0;
        step(0, 16'h00, 1, 2'b00);
        check("post_rst_count", queue_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
